timer_count_unit: RTL and testbench

//  Timebase stage of the timer, placed directly upstream of the compare/PWM output stage.
//  - Prescales clk and runs the 8-bit counter in up, down or up-down mode with a shadowed period.
//  - Produces counter_value, the run qualifier and the overflow pulse.
//  - Holds the sticky per-comparator flags built from the match vector returned by the output stage.

---
 rtl/timer_count_unit.sv | 208 ++++++++++++++++++++
 tb/tb_timer_count_unit.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_count_unit.sv
// timer_count_unit
// Timebase stage of the timer: a 2^presc_sel prescaler drives an 8-bit counter
// running up, down or up-down against a shadowed period. Produces the count,
// the run qualifier, a one-cycle overflow pulse with its sticky flag, and the
// sticky per-comparator flags built from the match vector of the output stage.
// Optional feature macro: TIMER_ONE_SHOT_EN. When defined, one_shot stops the
// timer after its first overflow; when undefined, one_shot is ignored.
module timer_count_unit #(
    parameter int NUM_COMP = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [2:0]          presc_sel,
    input  logic [7:0]          period,
    input  logic                sw_clear,
    input  logic                one_shot,
    input  logic [NUM_COMP-1:0] match,
    input  logic [NUM_COMP-1:0] flag_clr,
    input  logic                ovf_clr,
    output logic [7:0]          counter_value,
    output logic                running,
    output logic                dir,
    output logic                ovf,
    output logic                ovf_flag,
    output logic [NUM_COMP-1:0] flag
);

    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_UPDOWN = 2'b10;

    genvar gi;

    logic [6:0]          presc_cnt_reg, presc_cnt_next;
    logic [2:0]          presc_sel_reg, presc_sel_next;
    logic [6:0]          presc_term;
    logic [7:0]          shadow_reg, shadow_next;
    logic [7:0]          count_reg, count_next;
    logic [7:0]          down_val;
    logic                dir_reg, dir_next;
    logic                ovf_reg;
    logic                ovf_flag_reg, ovf_flag_next;
    logic [NUM_COMP-1:0] flag_reg, flag_next;
    logic [NUM_COMP-1:0] match_past_reg;
    logic                armed_reg;
    logic                stopped_reg;
    logic                running_int;
    logic                tick;
    logic                wrap;

`ifdef TIMER_ONE_SHOT_EN
    logic stopped_next;

    // One-shot stop: set on an overflow taken with one_shot high; released by sw_clear or en low
    always_comb begin
        stopped_next = stopped_reg;
        if (sw_clear || !en) begin
            stopped_next = 1'b0;
        end else if (wrap && one_shot) begin
            stopped_next = 1'b1;
        end
    end

    // One-shot stop register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stopped_reg <= 1'b0;
        end else begin
            stopped_reg <= stopped_next;
        end
    end
`else
    logic unused_one_shot;

    assign stopped_reg     = 1'b0;
    assign unused_one_shot = one_shot;
`endif

    // armed_reg keeps the timer idle during reset and for the first edge after
    // release, so running reads 0 while rst is high even with en held high.
    assign running_int = en & ~stopped_reg & armed_reg;

    // Terminal prescaler value 2^sel-1 as a mask, using the latched selection.
    assign presc_term = 7'h7F >> (3'd7 - presc_sel_reg);
    assign tick       = running_int & (presc_cnt_reg == presc_term);
    assign down_val   = count_reg - 8'd1;

    // Prescaler: counts while running, wraps on tick; a new presc_sel is only picked up at a wrap
    always_comb begin
        presc_cnt_next = presc_cnt_reg + 7'd1;
        presc_sel_next = presc_sel_reg;
        if (sw_clear || !running_int || tick) begin
            presc_cnt_next = 7'd0;
            presc_sel_next = presc_sel;
        end
    end

    // Counter and direction: sw_clear has priority, otherwise step once per tick
    always_comb begin
        count_next = count_reg;
        dir_next   = dir_reg;
        wrap       = 1'b0;
        if (sw_clear) begin
            count_next = (mode == MODE_DOWN) ? period : 8'd0;
            dir_next   = 1'b0;
        end else if (tick) begin
            case (mode)
                MODE_DOWN: begin
                    // Reload takes the incoming period, which is also what the shadow captures now.
                    dir_next = (shadow_reg != 8'd0);
                    if (count_reg == 8'd0) begin
                        count_next = period;
                        wrap       = 1'b1;
                    end else begin
                        count_next = down_val;
                    end
                end
                MODE_UPDOWN: begin
                    if (count_reg == 8'd0 && (dir_reg || shadow_reg == 8'd0)) begin
                        // Bottom reached while descending, or a zero period: hold 0 and overflow.
                        count_next = 8'd0;
                        dir_next   = 1'b0;
                        wrap       = 1'b1;
                    end else if (!dir_reg && count_reg == 8'hFF) begin
                        // Count left above the period by a mode/period change: natural wrap.
                        count_next = 8'd0;
                        dir_next   = 1'b0;
                        wrap       = 1'b1;
                    end else if (dir_reg || count_reg == shadow_reg) begin
                        count_next = down_val;
                        dir_next   = (down_val != 8'd0);
                        wrap       = (down_val == 8'd0);
                    end else begin
                        // dir flips on arrival at the top so it reads 1 while the top is shown.
                        count_next = count_reg + 8'd1;
                        dir_next   = (count_reg + 8'd1 == shadow_reg);
                    end
                end
                default: begin
                    // Up, and the reserved encoding treated as up.
                    dir_next = 1'b0;
                    if (count_reg == shadow_reg || count_reg == 8'hFF) begin
                        count_next = 8'd0;
                        wrap       = 1'b1;
                    end else begin
                        count_next = count_reg + 8'd1;
                    end
                end
            endcase
        end
    end

    // Shadow period: follows period while idle, otherwise only at overflow or sw_clear
    always_comb begin
        shadow_next = shadow_reg;
        if (sw_clear || !running_int || wrap) begin
            shadow_next = period;
        end
    end

    // Sticky overflow flag: set by the ovf pulse, cleared by ovf_clr, set wins
    always_comb begin
        ovf_flag_next = ovf_reg | (ovf_flag_reg & ~ovf_clr);
    end

    generate
        for (gi = 0; gi < NUM_COMP; gi++) begin : g_flag
            assign flag_next[gi] = (running_int & match[gi] & ~match_past_reg[gi])
                                 | (flag_reg[gi] & ~flag_clr[gi]);
        end
    endgenerate

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt_reg  <= 7'd0;
            presc_sel_reg  <= 3'd0;
            shadow_reg     <= 8'hFF;
            count_reg      <= 8'd0;
            dir_reg        <= 1'b0;
            ovf_reg        <= 1'b0;
            ovf_flag_reg   <= 1'b0;
            flag_reg       <= '0;
            match_past_reg <= '0;
            armed_reg      <= 1'b0;
        end else begin
            presc_cnt_reg  <= presc_cnt_next;
            presc_sel_reg  <= presc_sel_next;
            shadow_reg     <= shadow_next;
            count_reg      <= count_next;
            dir_reg        <= dir_next;
            ovf_reg        <= wrap;
            ovf_flag_reg   <= ovf_flag_next;
            flag_reg       <= flag_next;
            match_past_reg <= match;
            armed_reg      <= 1'b1;
        end
    end

    assign counter_value = count_reg;
    assign running       = running_int;
    assign dir           = dir_reg;
    assign ovf           = ovf_reg;
    assign ovf_flag      = ovf_flag_reg;
    assign flag          = flag_reg;

endmodule

// File: tb/tb_timer_count_unit.sv
// Testbench for timer_count_unit: directed scenarios with constant expectations
// followed by randomized stimulus checked against a behavioural model.
module tb_timer_count_unit;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [2:0] presc_sel;
    logic [7:0] period;
    logic       sw_clear;
    logic       one_shot;
    logic [2:0] match;
    logic [2:0] flag_clr;
    logic       ovf_clr;
    logic [7:0] counter_value;
    logic       running;
    logic       dir;
    logic       ovf;
    logic       ovf_flag;
    logic [2:0] flag;

    logic [14:0] dut_vec;
    int vectors;
    int miscompares;

    // Behavioural model state
    int m_cnt, m_dir, m_ovf, m_ovf_flag, m_shadow, m_stopped, m_armed;
    int m_since;   // clk cycles elapsed in the current prescaler period
    int m_div;     // division ratio currently in force
    bit [2:0] m_flag, m_mpast;

    timer_count_unit #(.NUM_COMP(3)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .presc_sel(presc_sel),
        .period(period), .sw_clear(sw_clear), .one_shot(one_shot),
        .match(match), .flag_clr(flag_clr), .ovf_clr(ovf_clr),
        .counter_value(counter_value), .running(running), .dir(dir),
        .ovf(ovf), .ovf_flag(ovf_flag), .flag(flag)
    );

    assign dut_vec = {counter_value, dir, ovf, ovf_flag, flag, running};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_cnt = 0; m_dir = 0; m_ovf = 0; m_ovf_flag = 0; m_flag = '0;
        m_shadow = 255; m_stopped = 0; m_mpast = '0; m_since = 0; m_div = 1;
        m_armed = 0;
    endtask

    function automatic logic [14:0] m_vec();
        logic r;
        r = en && (m_stopped == 0) && (m_armed != 0);
        return {m_cnt[7:0], m_dir[0], m_ovf[0], m_ovf_flag[0], m_flag, r};
    endfunction

    // One clock of the timer, phrased as the rules of each counting mode.
    task automatic model_step();
        bit run, tk, wrap;
        int p, c, nc, nd;
        if (rst) begin
            model_reset();
            return;
        end
        run  = en && (m_stopped == 0) && (m_armed != 0);
        tk   = run && (m_since == m_div - 1);
        p    = m_shadow;
        c    = m_cnt;
        nc   = c;
        nd   = m_dir;
        wrap = 0;
        if (sw_clear) begin
            nc = (mode == 2'd1) ? int'(period) : 0;
            nd = 0;
        end else if (tk) begin
            if (mode == 2'd1) begin
                // down: P..0 then reload with the period being latched now
                nd = (p != 0);
                if (c == 0) begin nc = int'(period); wrap = 1; end
                else nc = c - 1;
            end else if (mode == 2'd2) begin
                // up-down: climb to P, fall to 0, overflow on reaching 0
                if (c == 0 && (m_dir == 1 || p == 0)) begin
                    nc = 0; nd = 0; wrap = 1;
                end else if (m_dir == 0 && c == 255) begin
                    nc = 0; nd = 0; wrap = 1;
                end else if (m_dir == 1 || c == p) begin
                    nc = c - 1;
                    nd = (nc > 0) ? 1 : 0;
                    wrap = (nc == 0);
                end else begin
                    nc = c + 1;
                    nd = (nc == p) ? 1 : 0;
                end
            end else begin
                // up: 0..P then 0; beyond P run on to 255 and wrap
                nd = 0;
                if (c == p || c == 255) begin nc = 0; wrap = 1; end
                else nc = c + 1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (run && match[i] && !m_mpast[i]) m_flag[i] = 1'b1;
            else if (flag_clr[i]) m_flag[i] = 1'b0;
        end
        if (m_ovf != 0) m_ovf_flag = 1;
        else if (ovf_clr) m_ovf_flag = 0;
        m_mpast = match;
        if (sw_clear || !run || wrap) m_shadow = int'(period);
        if (sw_clear || !run || tk) begin
            m_since = 0;
            m_div   = 1 << presc_sel;
        end else begin
            m_since++;
        end
`ifdef TIMER_ONE_SHOT_EN
        if (sw_clear || !en) m_stopped = 0;
        else if (wrap && one_shot) m_stopped = 1;
`endif
        m_cnt   = nc;
        m_dir   = nd;
        m_ovf   = wrap ? 1 : 0;
        m_armed = 1;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1;
        #1;
        vectors++;
        if (dut_vec !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state: outputs=%h expected 0", dut_vec);
        end
        cyc();
        vectors++;
        if (dut_vec !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_held: outputs=%h expected 0", dut_vec);
        end
        rst = 0; en = 0;
        cyc();
        vectors++;
        if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL reset_release: outputs=%h expected %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_up_basic();
        int exp_cnt[6] = '{1, 2, 3, 4, 0, 1};
        int exp_ovf[6] = '{0, 0, 0, 0, 1, 0};
        mode = 2'd0; presc_sel = 3'd0; period = 8'd4; en = 1;
        sw_clear = 1; ovf_clr = 1;
        cyc();
        sw_clear = 0; ovf_clr = 0;
        vectors++;
        if (counter_value !== 8'd0 || ovf_flag !== 1'b0 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL up_start: cnt=%0d ovf_flag=%b running=%b expected 0,0,1",
                     counter_value, ovf_flag, running);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            vectors++;
            if (counter_value !== 8'(exp_cnt[i]) || ovf !== 1'(exp_ovf[i])) begin
                miscompares++;
                $display("FAIL up_seq[%0d]: cnt=%0d ovf=%b expected cnt=%0d ovf=%0d",
                         i, counter_value, ovf, exp_cnt[i], exp_ovf[i]);
            end
        end
        vectors++;
        if (ovf_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL up_ovf_flag: ovf_flag=%b expected 1", ovf_flag);
        end
    endtask

    task automatic test_prescaler();
        int exp2[5] = '{2, 2, 3, 4, 5};
        mode = 2'd0; presc_sel = 3'd2; period = 8'hFF; sw_clear = 1;
        cyc();
        sw_clear = 0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            vectors++;
            if (counter_value !== 8'(k / 4)) begin
                miscompares++;
                $display("FAIL presc_div4[%0d]: cnt=%0d expected %0d", k, counter_value, k / 4);
            end
        end
        presc_sel = 3'd0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            vectors++;
            if (counter_value !== 8'(exp2[k])) begin
                miscompares++;
                $display("FAIL presc_switch[%0d]: cnt=%0d expected %0d", k, counter_value, exp2[k]);
            end
        end
    endtask

    task automatic test_updown();
        int exp_cnt[12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
        int exp_dir[12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        int ovf_seen;
        ovf_seen = 0;
        mode = 2'd2; period = 8'd3; presc_sel = 3'd0; sw_clear = 1;
        cyc();
        sw_clear = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ovf === 1'b1) ovf_seen++;
            vectors++;
            if (counter_value !== 8'(exp_cnt[i]) || dir !== 1'(exp_dir[i])) begin
                miscompares++;
                $display("FAIL updown_seq[%0d]: cnt=%0d dir=%b expected cnt=%0d dir=%0d",
                         i, counter_value, dir, exp_cnt[i], exp_dir[i]);
            end
        end
        vectors++;
        if (ovf_seen != 2) begin
            miscompares++;
            $display("FAIL updown_ovf_count: saw %0d expected 2", ovf_seen);
        end
    endtask

    task automatic test_down_reload();
        int exp_cnt[5] = '{1, 0, 5, 4, 3};
        int exp_ovf[5] = '{0, 0, 1, 0, 0};
        mode = 2'd1; period = 8'd2; sw_clear = 1;
        cyc();
        sw_clear = 0;
        vectors++;
        if (counter_value !== 8'd2 || dir !== 1'b0) begin
            miscompares++;
            $display("FAIL down_clear: cnt=%0d dir=%b expected 2,0", counter_value, dir);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) period = 8'd5;
            vectors++;
            if (counter_value !== 8'(exp_cnt[i]) || ovf !== 1'(exp_ovf[i])) begin
                miscompares++;
                $display("FAIL down_seq[%0d]: cnt=%0d ovf=%b expected cnt=%0d ovf=%0d",
                         i, counter_value, ovf, exp_cnt[i], exp_ovf[i]);
            end
        end
    endtask

    task automatic test_shadow_period();
        int exp_cnt[10] = '{2, 3, 0, 1, 2, 3, 4, 5, 6, 0};
        mode = 2'd0; period = 8'd3; sw_clear = 1;
        cyc();
        sw_clear = 0;
        cyc();
        period = 8'd6;
        for (int i = 0; i < 10; i++) begin
            cyc();
            vectors++;
            if (counter_value !== 8'(exp_cnt[i])) begin
                miscompares++;
                $display("FAIL shadow_seq[%0d]: cnt=%0d expected %0d", i, counter_value, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_flags();
        logic [7:0] held;
        en = 1; match = 3'b000; flag_clr = 3'b111;
        cyc();
        flag_clr = 3'b000;
        match = 3'b010; flag_clr = 3'b010;
        cyc();
        vectors++;
        if (flag !== 3'b010) begin
            miscompares++;
            $display("FAIL flag_set_wins: flag=%b expected 010", flag);
        end
        flag_clr = 3'b010;
        cyc();
        flag_clr = 3'b000;
        vectors++;
        if (flag !== 3'b000) begin
            miscompares++;
            $display("FAIL flag_clear: flag=%b expected 000", flag);
        end
        match = 3'b000;
        cyc();
        en = 0; match = 3'b001;
        cyc();
        held = counter_value;
        vectors++;
        if (flag !== 3'b000 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL flag_idle_set: flag=%b running=%b expected 000,0", flag, running);
        end
        en = 1;
        cyc();
        vectors++;
        if (flag !== 3'b000) begin
            miscompares++;
            $display("FAIL match_past_idle: flag=%b expected 000", flag);
        end
        match = 3'b000;
        cyc();
        match = 3'b001;
        cyc();
        vectors++;
        if (flag !== 3'b001) begin
            miscompares++;
            $display("FAIL flag_rise: flag=%b expected 001", flag);
        end
        en = 0; flag_clr = 3'b001;
        cyc();
        held = counter_value;
        flag_clr = 3'b000; ovf_clr = 1;
        cyc();
        ovf_clr = 0;
        cyc();
        cyc();
        vectors++;
        if (flag !== 3'b000 || ovf_flag !== 1'b0 || ovf !== 1'b0 || counter_value !== held) begin
            miscompares++;
            $display("FAIL en_low: flag=%b ovf_flag=%b ovf=%b cnt=%0d expected 000,0,0,%0d",
                     flag, ovf_flag, ovf, counter_value, held);
        end
        match = 3'b000;
        en = 1;
        cyc();
    endtask

    task automatic test_rst_midcount();
        mode = 2'd0; period = 8'd20; presc_sel = 3'd0; en = 1; sw_clear = 1;
        cyc();
        sw_clear = 0;
        match = 3'b100;
        for (int i = 0; i < 7; i++) cyc();
        match = 3'b000;
        vectors++;
        if (counter_value !== 8'd7 || flag !== 3'b100) begin
            miscompares++;
            $display("FAIL rst_pre: cnt=%0d flag=%b expected 7,100", counter_value, flag);
        end
        #2;
        rst = 1;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== 15'd0) begin
            miscompares++;
            $display("FAIL rst_async: outputs=%h expected 0", dut_vec);
        end
        cyc();
        rst = 0;
        cyc();
        vectors++;
        if (counter_value !== 8'd0 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_resume0: cnt=%0d running=%b expected 0,1", counter_value, running);
        end
        cyc();
        vectors++;
        if (counter_value !== 8'd1) begin
            miscompares++;
            $display("FAIL rst_resume1: cnt=%0d expected 1", counter_value);
        end
    endtask

    task automatic test_one_shot();
`ifdef TIMER_ONE_SHOT_EN
        int exp_cnt[5] = '{1, 2, 0, 0, 0};
        int exp_run[5] = '{1, 1, 0, 0, 0};
        mode = 2'd0; period = 8'd2; presc_sel = 3'd0; en = 1; one_shot = 1; sw_clear = 1;
        cyc();
        sw_clear = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if (counter_value !== 8'(exp_cnt[i]) || running !== 1'(exp_run[i])) begin
                miscompares++;
                $display("FAIL one_shot[%0d]: cnt=%0d running=%b expected %0d,%0d",
                         i, counter_value, running, exp_cnt[i], exp_run[i]);
            end
        end
        sw_clear = 1;
        cyc();
        sw_clear = 0; one_shot = 0;
        vectors++;
        if (running !== 1'b1 || counter_value !== 8'd0) begin
            miscompares++;
            $display("FAIL one_shot_restart: running=%b cnt=%0d expected 1,0", running, counter_value);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                presc_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 29) == 0)
                period = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            sw_clear = ($urandom_range(0, 63) == 0);
            one_shot = 1'($urandom_range(0, 1));
            match    = 3'($urandom_range(0, 7));
            flag_clr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            ovf_clr  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 699) == 0) begin
                #2;
                rst = 1;
                #1;
                model_reset();
                vectors++;
                if (dut_vec !== m_vec()) begin
                    miscompares++;
                    $display("FAIL random_rst[%0d]: outputs=%h expected %h", n, dut_vec, m_vec());
                end
                cyc();
                rst = 0;
            end
            cyc();
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: outputs=%h expected %h (mode=%0d period=%0d)",
                         n, dut_vec, m_vec(), mode, period);
            end
        end
    endtask

    initial begin
        clk = 0; rst = 1; en = 0; mode = 2'd0; presc_sel = 3'd0; period = 8'd0;
        sw_clear = 0; one_shot = 0; match = 3'b000; flag_clr = 3'b000; ovf_clr = 0;
        vectors = 0; miscompares = 0;
        model_reset();
        test_reset();
        test_up_basic();
        test_prescaler();
        test_updown();
        test_down_reload();
        test_shadow_period();
        test_flags();
        test_rst_midcount();
        test_one_shot();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
